// File: rtl/pwm_audio_out.sv
// pwm_audio_out: turns the mixer sample word into a 1-bit audio stream for an
// external RC low-pass filter. Output is either fixed-period PWM or first-order
// sigma-delta pulse density. Duty and mode are latched only at period
// boundaries, so an update can never truncate or glitch a pulse in flight.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_in    unsigned sample, latched at each period boundary
//   enable       1 = run, 0 = park idle with output low
//   mode         0 = PWM, 1 = sigma-delta, latched at each period boundary
//   pwm_out      registered 1-bit audio output
//   period_start registered one-clock pulse on each period boundary
module pwm_audio_out #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             enable,
  input  logic             mode,
  output logic             pwm_out,
  output logic             period_start
);

  localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;

  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   sd_sum;

  // One sigma-delta step: the carry out of the WIDTH-bit accumulator is the
  // output bit, the low WIDTH bits are the new accumulator.
  function automatic logic [WIDTH:0] sd_step(input logic [WIDTH-1:0] acc,
                                             input logic [WIDTH-1:0] duty);
    sd_step = {1'b0, acc} + {1'b0, duty};
  endfunction

  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    pwm_d    = pwm_q;
    ps_d     = 1'b0;
    tick     = (pre_q == PRE_MAX);
    boundary = tick && (cnt_q == CNT_MAX);
    acc_base = acc_q;
    sd_sum   = '0;

    if (!enable) begin
      // Park the counter at max so the first tick after enable is a boundary
      // and a fresh sample is latched before anything is played.
      pre_d = '0;
      cnt_d = CNT_MAX;
      acc_d = '0;
      pwm_d = 1'b0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (boundary) begin
          cnt_d  = '0;
          duty_d = sample_in;
          mode_d = mode;
          ps_d   = 1'b1;
          // Start the modulator from a known state whenever the mode flips.
          if (mode != mode_q) begin
            acc_base = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        sd_sum = sd_step(acc_base, duty_d);
        if (mode_d) begin
          pwm_d = sd_sum[WIDTH];
          acc_d = sd_sum[WIDTH-1:0];
        end else begin
          pwm_d = (cnt_d < duty_d);
          acc_d = acc_base;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      cnt_q  <= CNT_MAX;
      duty_q <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      pwm_q  <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Testbench for pwm_audio_out: a DIV=1 and a DIV=4 instance share stimulus.
// A table of per-period {sample, mode} records drives the DIV=1 instance; the
// expected high count, first output bit and number of rising edges for each
// period go into a queue and are checked when the period completes. Hand
// sequences cover enable drop, async reset and the DIV=4 prescaler.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       pwm1, ps1, pwm4, ps4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_audio_out #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .enable(enable),
    .mode(mode), .pwm_out(pwm1), .period_start(ps1)
  );

  pwm_audio_out #(.WIDTH(8), .DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .enable(enable),
    .mode(mode), .pwm_out(pwm4), .period_start(ps4)
  );

  typedef struct {
    logic [7:0] sample;
    logic       md;
    int         delay;     // clocks after a boundary before driving
    int         exp_high;
    int         exp_first;
    int         exp_rises;
  } vec_t;

  typedef struct {
    int idx;
    int exp_high;
    int exp_first;
    int exp_rises;
  } sb_t;

  sb_t sb[$];
  bit  mon_en = 1'b0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps1(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps1 && n < 2000);
    check(name, int'(ps1), 1);
  endtask

  // Per-period monitor on the DIV=1 instance.
  int in_per = 0, highs = 0, first = 0, rises = 0, plen = 0, prev = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      in_per = 0;
    end else if (ps1) begin
      if (in_per != 0) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check($sformatf("period%0d_high", e.idx), highs, e.exp_high);
          check($sformatf("period%0d_first", e.idx), first, e.exp_first);
          check($sformatf("period%0d_rises", e.idx), rises, e.exp_rises);
          check($sformatf("period%0d_len", e.idx), plen, 256);
        end
      end
      in_per = 1;
      highs  = int'(pwm1);
      first  = int'(pwm1);
      prev   = int'(pwm1);
      rises  = 0;
      plen   = 1;
    end else if (in_per != 0) begin
      highs += int'(pwm1);
      if (pwm1 && prev == 0) rises++;
      prev = int'(pwm1);
      plen++;
    end
  end

  vec_t tbl[9];

  initial begin
    int cnt, len, bad, idx, pv;

    tbl[0] = '{8'h40, 1'b0, 0,   64,  1, 0};
    tbl[1] = '{8'h00, 1'b0, 0,   0,   0, 0};
    tbl[2] = '{8'hFF, 1'b0, 0,   255, 1, 0};
    tbl[3] = '{8'h40, 1'b0, 0,   64,  1, 0};
    tbl[4] = '{8'hC0, 1'b0, 30,  192, 1, 0};   // changed 30 clocks into a 0x40 period
    tbl[5] = '{8'h80, 1'b1, 100, 128, 0, 128}; // mode flipped mid-period
    tbl[6] = '{8'h40, 1'b1, 0,   64,  0, 64};
    tbl[7] = '{8'h01, 1'b1, 0,   1,   0, 1};
    tbl[8] = '{8'h10, 1'b0, 50,  16,  1, 0};

    // Asynchronous reset, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_pwm1", int'(pwm1), 0);
    check("reset_ps1", int'(ps1), 0);
    check("reset_pwm4", int'(pwm4), 0);
    check("reset_ps4", int'(ps4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (pwm1 || ps1) cnt++;
    end
    check("disabled_idle", cnt, 0);

    // Table-driven periods through the scoreboard.
    sample_in = tbl[0].sample;
    mode      = tbl[0].md;
    sb.push_back('{0, tbl[0].exp_high, tbl[0].exp_first, tbl[0].exp_rises});
    mon_en = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("first_boundary_on_enable", int'(ps1), 1);
    for (int i = 1; i < 9; i++) begin
      if (i > 1) wait_ps1($sformatf("boundary%0d", i));
      repeat (tbl[i].delay) @(negedge clk);
      sample_in = tbl[i].sample;
      mode      = tbl[i].md;
      sb.push_back('{i, tbl[i].exp_high, tbl[i].exp_first, tbl[i].exp_rises});
    end
    wait_ps1("boundary_tail0");
    wait_ps1("boundary_tail1");
    @(posedge clk);
    mon_en = 1'b0;
    check("sb_drained", sb.size(), 0);

    // Drop enable mid-pulse (0x10 PWM period is playing).
    repeat (4) @(negedge clk);
    check("pre_drop_high", int'(pwm1), 1);
    enable = 1'b0;
    @(negedge clk);
    check("drop_pwm", int'(pwm1), 0);
    check("drop_ps", int'(ps1), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm1 || ps1) cnt++;
    end
    check("drop_hold_low", cnt, 0);

    // Re-enable with 0x20: boundary on the first clock, 32-tick pulse.
    sample_in = 8'h20;
    mode      = 1'b0;
    enable    = 1'b1;
    @(negedge clk);
    check("reen_ps", int'(ps1), 1);
    check("reen_pwm", int'(pwm1), 1);
    cnt = int'(pwm1);
    len = 1;
    do begin
      @(negedge clk);
      if (!ps1) begin
        cnt += int'(pwm1);
        len++;
      end
    end while (!ps1 && len < 400);
    check("reen_high", cnt, 32);
    check("reen_len", len, 256);

    // Async reset mid-pulse, then release behaves like an enable restart.
    repeat (5) @(negedge clk);
    check("pre_reset_high", int'(pwm1), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_pwm1", int'(pwm1), 0);
    check("midreset_ps1", int'(ps1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postreset_ps", int'(ps1), 1);
    cnt = int'(pwm1);
    len = 1;
    do begin
      @(negedge clk);
      if (!ps1) begin
        cnt += int'(pwm1);
        len++;
      end
    end while (!ps1 && len < 400);
    check("postreset_high", cnt, 32);
    check("postreset_len", len, 256);

    // DIV=4, PWM 0x10.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    sample_in = 8'h10;
    mode      = 1'b0;
    enable    = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ps4 && cnt < 20);
    check("div4_first_boundary", cnt, 4);
    check("div4_first_pwm", int'(pwm4), 1);
    cnt = 1;
    len = 1;
    bad = 0;
    idx = 0;
    pv  = int'(pwm4);
    do begin
      @(negedge clk);
      idx++;
      if (!ps4) begin
        cnt += int'(pwm4);
        len++;
        if (int'(pwm4) != pv && (idx % 4) != 0) bad++;
        pv = int'(pwm4);
      end
    end while (!ps4 && len < 3000);
    check("div4_high", cnt, 64);
    check("div4_len", len, 1024);
    check("div4_offtick_edges", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
